// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the 32-bit timer counting engine.
// Contents:
//   - FSM state encoding (IDLE, LOAD, RUN, DONE).
//   - Bit positions of the fields in the control register.
package timer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t LOAD = 2'd1;
    localparam state_t RUN  = 2'd2;
    localparam state_t DONE = 2'd3;

    localparam int unsigned CTRL_EN  = 0;
    localparam int unsigned CTRL_AR  = 1;
    localparam int unsigned CTRL_IRQ = 3;
    localparam int unsigned CTRL_CLR = 4;

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides the clock by (limit + 1) while the timer is running.
// Ports:
//   clock  in   system clock
//   reset  in   synchronous active-high reset
//   clear  in   forces the prescale counter back to 0
//   run    in   counter advances only while high
//   limit  in   prescale value S; tick fires when the counter equals it
//   tick   out  one-cycle pulse on each compare match
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             run,
    input  logic [WIDTH-1:0] limit,
    output logic             tick
);

    localparam logic [WIDTH-1:0] ONE = 1;

    logic [WIDTH-1:0] pcnt_q;
    logic             match;

    // Full-width equality compare, so limit = all-ones never overflows pcnt.
    assign match = (pcnt_q == limit);
    assign tick  = run & ~clear & match;

    always_ff @(posedge clock) begin
        if (reset) begin
            pcnt_q <= '0;
        end else if (clear) begin
            pcnt_q <= '0;
        end else if (run) begin
            pcnt_q <= match ? '0 : pcnt_q + ONE;
        end
    end

endmodule

// File: rtl/timer_32b_core.sv
// timer_32b_core: counting engine of the 32-bit Avalon timer peripheral.
// Ports:
//   clock     in   system clock
//   reset     in   synchronous active-high reset
//   ctrl      in   control: bit0 enable, bit1 auto_reload, bit3 irq_en, bit4 clr
//   period    in   reload value P, sampled at LOAD and at auto-reload
//   prescale  in   prescale divisor minus one S, sampled on each compare
//   data      out  current count value
//   we        out  one-cycle strobe marking a new count value on data
//   expired   out  sticky expiry flag, cleared by a clr rising edge
//   irq       out  registered level interrupt (expired & irq_en)
// Build option: define TIMER_IRQ_EN to generate irq; otherwise irq is tied to 0
// and ctrl[3] is ignored.
module timer_32b_core
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      ctrl,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] prescale,
    output logic [WIDTH-1:0] data,
    output logic             we,
    output logic             expired,
    output logic             irq
);

    localparam logic [WIDTH-1:0] ONE = 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             we_q, we_d;
    logic             expired_q, expired_d;
    logic             en_q, clr_q;

    logic en_rise, clr_rise;
    logic enable;
    logic tick;
    logic pre_run, pre_clear;
    logic expire;

    assign enable   = ctrl[CTRL_EN];
    assign en_rise  = enable & ~en_q;
    assign clr_rise = ctrl[CTRL_CLR] & ~clr_q;

    assign pre_run   = (state_q == RUN);
    // Prescaler restarts from 0 whenever the engine leaves RUN or is disabled.
    assign pre_clear = (state_q != RUN) | ~enable;

    timer_prescaler #(
        .WIDTH (WIDTH)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .clear (pre_clear),
        .run   (pre_run),
        .limit (prescale),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        we_d    = 1'b0;
        expire  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en_rise) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                count_d = period;
                we_d    = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                // Disable wins over a coincident tick; count is held.
                if (!enable) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (count_q != '0) begin
                        count_d = count_q - ONE;
                        we_d    = 1'b1;
                    end else begin
                        expire = 1'b1;
                        if (ctrl[CTRL_AR]) begin
                            count_d = period;
                            we_d    = 1'b1;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (!enable) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Expiry takes priority over a clr edge in the same cycle.
    always_comb begin
        expired_d = expired_q;
        if (expire) begin
            expired_d = 1'b1;
        end else if (clr_rise) begin
            expired_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            we_q      <= 1'b0;
            expired_q <= 1'b0;
            en_q      <= 1'b0;
            clr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            we_q      <= we_d;
            expired_q <= expired_d;
            en_q      <= enable;
            clr_q     <= ctrl[CTRL_CLR];
        end
    end

    assign data    = count_q;
    assign we      = we_q;
    assign expired = expired_q;

`ifdef TIMER_IRQ_EN
    logic irq_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= expired_q & ctrl[CTRL_IRQ];
        end
    end

    assign irq = irq_q;

    logic unused_ctrl;
    assign unused_ctrl = ^{ctrl[31:5], ctrl[2]};
`else
    assign irq = 1'b0;

    logic unused_ctrl;
    assign unused_ctrl = ^{ctrl[31:5], ctrl[3:2]};
`endif

endmodule

// File: tb/tb_timer_32b_core.sv
// tb_timer_32b_core: directed self-checking bench for timer_32b_core.
// Cycle numbering: cycle 0 is the cycle in which the enable edge is driven;
// inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_timer_32b_core;
    import timer_pkg::*;

`ifdef TIMER_IRQ_EN
    localparam logic IRQ_BUILT = 1'b1;
`else
    localparam logic IRQ_BUILT = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ctrl = '0;
    logic [31:0] period = '0;
    logic [31:0] prescale = '0;
    logic [31:0] data;
    logic        we;
    logic        expired;
    logic        irq;

    int checks = 0;
    int failures = 0;

    timer_32b_core #(
        .WIDTH (32)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .ctrl     (ctrl),
        .period   (period),
        .prescale (prescale),
        .data     (data),
        .we       (we),
        .expired  (expired),
        .irq      (irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        ctrl  = '0;
        step(2);
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        step(1);
        apply_reset();
        check("rst_data", data, 32'd0);
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_expired", {31'd0, expired}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_state", {30'd0, dut.state_q}, {30'd0, IDLE});

        // One-shot P=3 S=0 irq_en
        period = 32'd3; prescale = 32'd0; ctrl = 32'h9;
        step(1);
        check("os_load_state", {30'd0, dut.state_q}, {30'd0, LOAD});
        step(1);
        for (int i = 0; i < 4; i++) begin
            check("os_data", data, 32'(3 - i));
            check("os_we", {31'd0, we}, 32'd1);
            check("os_exp_low", {31'd0, expired}, 32'd0);
            step(1);
        end
        check("os_expired_c6", {31'd0, expired}, 32'd1);
        check("os_irq_c6", {31'd0, irq}, 32'd0);
        check("os_we_c6", {31'd0, we}, 32'd0);
        step(1);
        check("os_irq_c7", {31'd0, irq}, {31'd0, IRQ_BUILT});
        check("os_state_done", {30'd0, dut.state_q}, {30'd0, DONE});
        check("os_data_hold", data, 32'd0);
        check("os_we_c7", {31'd0, we}, 32'd0);

        // Auto-reload P=2 S=0
        apply_reset();
        period = 32'd2; ctrl = 32'h3;
        step(2);
        for (int i = 0; i < 6; i++) begin
            check("ar_data", data, 32'(2 - (i % 3)));
            check("ar_we", {31'd0, we}, 32'd1);
            check("ar_expired", {31'd0, expired}, (i >= 3) ? 32'd1 : 32'd0);
            step(1);
        end

        // P=1 S=2
        apply_reset();
        period = 32'd1; prescale = 32'd2; ctrl = 32'h1;
        step(2);
        for (int i = 0; i < 6; i++) begin
            check("ps_data", data, (i < 3) ? 32'd1 : 32'd0);
            check("ps_we", {31'd0, we}, (i == 0 || i == 3) ? 32'd1 : 32'd0);
            check("ps_exp_low", {31'd0, expired}, 32'd0);
            step(1);
        end
        check("ps_expired", {31'd0, expired}, 32'd1);
        check("ps_state_done", {30'd0, dut.state_q}, {30'd0, DONE});

        // clr edge in the exact expiry cycle, then an isolated clr edge
        apply_reset();
        period = 32'd3; prescale = 32'd0; ctrl = 32'h9;
        step(5);
        check("clr_pre_exp", {31'd0, expired}, 32'd0);
        ctrl = 32'h19;
        step(1);
        check("clr_exp_wins", {31'd0, expired}, 32'd1);
        step(1);
        check("clr_irq_on", {31'd0, irq}, {31'd0, IRQ_BUILT});
        ctrl = 32'h09;
        step(1);
        check("clr_still_set", {31'd0, expired}, 32'd1);
        ctrl = 32'h19;
        step(1);
        check("clr_expired_off", {31'd0, expired}, 32'd0);
        check("clr_irq_lag", {31'd0, irq}, {31'd0, IRQ_BUILT});
        step(1);
        check("clr_irq_off", {31'd0, irq}, 32'd0);

        // Drop enable at data=5 with P=9, then re-enable
        apply_reset();
        period = 32'd9; prescale = 32'd0; ctrl = 32'h1;
        step(6);
        check("dis_data5", data, 32'd5);
        ctrl = 32'h0;
        step(1);
        check("dis_state", {30'd0, dut.state_q}, {30'd0, IDLE});
        check("dis_hold", data, 32'd5);
        check("dis_we", {31'd0, we}, 32'd0);
        step(1);
        check("dis_hold2", data, 32'd5);
        ctrl = 32'h1;
        step(1);
        check("reen_load", data, 32'd5);
        step(1);
        check("reen_data", data, 32'd9);
        check("reen_we", {31'd0, we}, 32'd1);

        // P=0 expires on the first tick after LOAD
        apply_reset();
        period = 32'd0; prescale = 32'd0; ctrl = 32'h1;
        step(2);
        check("p0_data", data, 32'd0);
        check("p0_we", {31'd0, we}, 32'd1);
        step(1);
        check("p0_expired", {31'd0, expired}, 32'd1);
        check("p0_state", {30'd0, dut.state_q}, {30'd0, DONE});

        // S = all ones: no tick within a short window
        apply_reset();
        period = 32'd0; prescale = 32'hFFFF_FFFF; ctrl = 32'h1;
        step(22);
        check("smax_expired", {31'd0, expired}, 32'd0);
        check("smax_state", {30'd0, dut.state_q}, {30'd0, RUN});
        check("smax_we", {31'd0, we}, 32'd0);

        // Reset mid-RUN with expired set
        apply_reset();
        period = 32'd2; prescale = 32'd0; ctrl = 32'hB;
        step(6);
        check("mr_expired", {31'd0, expired}, 32'd1);
        reset = 1'b1;
        step(1);
        check("mr_data", data, 32'd0);
        check("mr_we", {31'd0, we}, 32'd0);
        check("mr_expired0", {31'd0, expired}, 32'd0);
        check("mr_irq", {31'd0, irq}, 32'd0);
        check("mr_state", {30'd0, dut.state_q}, {30'd0, IDLE});
        reset = 1'b0;
        ctrl  = '0;
        step(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
